sev_seg_scan: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the per-digit binary-to-segment decoders: it takes four active-high segment patterns, buffers them as one frame, and scans them onto shared active-low cathodes and one-hot active-low anodes. Inter-digit blanking suppresses ghosting, and a double-buffered frame register keeps updates tear-free.

---
 rtl/sev_seg_pkg.sv | 27 ++
 rtl/sev_seg_frame_buf.sv | 40 ++++
 rtl/sev_seg_scan.sv | 104 ++++++++++
 tb/tb_sev_seg_scan.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared constants, frame type and small helpers for the seven-segment scanner.
package sev_seg_pkg;

  localparam int SEG_W      = 7;
  localparam int NUM_DIGITS = 4;

  localparam logic [SEG_W-1:0]      SEG_BLANK_N = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF_N    = 4'b1111;

  // One complete display frame: active-high patterns, decimal points, enables.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][SEG_W-1:0] seg;
    logic [NUM_DIGITS-1:0]            dp;
    logic [NUM_DIGITS-1:0]            en;
  } frame_t;

  localparam frame_t FRAME_CLEAR = '0;

  // Active-low one-hot anode select for digit idx.
  function automatic logic [NUM_DIGITS-1:0] anode_sel_n(input logic [1:0] idx);
    logic [NUM_DIGITS-1:0] sel;
    sel      = AN_OFF_N;
    sel[idx] = 1'b0;
    return sel;
  endfunction

endpackage

// File: rtl/sev_seg_frame_buf.sv
// Double-buffered frame store: a pending frame collects loads, and the
// active frame only changes on a frame boundary so a frame is never mixed.
module sev_seg_frame_buf
  import sev_seg_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   boundary,
  input  frame_t frame_in,
  output frame_t active
);

  frame_t pending;
  logic   pending_valid;

  // Pending/active update; a load on the boundary itself bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= FRAME_CLEAR;
      active        <= FRAME_CLEAR;
      pending_valid <= 1'b0;
    end else if (boundary) begin
      pending_valid <= 1'b0;
      if (load) begin
        active <= frame_in;
      end else if (pending_valid) begin
        active <= pending;
      end else begin
        active <= active;
      end
    end else if (load) begin
      pending       <= frame_in;
      pending_valid <= 1'b1;
    end else begin
      pending_valid <= pending_valid;
    end
  end

endmodule

// File: rtl/sev_seg_scan.sv
// Four-digit common-anode scanner: slot counter, digit index, inter-digit
// blanking and registered active-low cathode/anode outputs.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic                        load,
  output logic [SEG_W-1:0]            seg_n,
  output logic                        dp_n,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic                        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]      div_cnt;
  logic [1:0]            idx;
  logic                  boundary;
  logic                  lit;
  frame_t                frame_in;
  frame_t                active;
  logic [SEG_W-1:0]      seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  // Repack the flat decoder bus into a frame.
  always_comb begin
    frame_in    = FRAME_CLEAR;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      frame_in.seg[d] = seg_in[SEG_W*d +: SEG_W];
    end
    frame_in.dp = dp_in;
    frame_in.en = digit_en;
  end

  // Last cycle of the last slot marks the frame boundary.
  always_comb begin
    boundary = (div_cnt == LAST_CNT) && (idx == 2'd3);
  end

  sev_seg_frame_buf u_frame_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .boundary (boundary),
    .frame_in (frame_in),
    .active   (active)
  );

  // Slot divider and digit index; idx wraps 3->0 with the divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (div_cnt == LAST_CNT) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Next output values from the current slot position and active frame.
  always_comb begin
    lit     = (div_cnt >= BLANK_CNT) && active.en[idx];
    an_nxt  = AN_OFF_N;
    seg_nxt = SEG_BLANK_N;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt  = anode_sel_n(idx);
      seg_nxt = ~active.seg[idx];
      dp_nxt  = ~active.dp[idx];
    end else begin
      an_nxt  = AN_OFF_N;
      seg_nxt = SEG_BLANK_N;
      dp_nxt  = 1'b1;
    end
  end

  // Registered outputs; reset forces the display dark immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= AN_OFF_N;
      seg_n      <= SEG_BLANK_N;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= an_nxt;
      seg_n      <= seg_nxt;
      dp_n       <= dp_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed bench for sev_seg_scan with an edge-count based display model.
module tb_sev_seg_scan;

  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] seg_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int vectors = 0;
  int misc    = 0;

  // model state: edges since reset, active and pending frames
  int         k = 0;
  logic [6:0] a_seg[4];
  logic [6:0] p_seg[4];
  logic [3:0] a_dp = '0, a_en = '0, p_dp = '0, p_en = '0;
  bit         pv = 1'b0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp = 1'b1;
  logic       exp_fd = 1'b0;

  sev_seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  // Model: position in frame comes from the edge count alone.
  initial begin
    for (int d = 0; d < 4; d++) begin
      a_seg[d] = '0;
      p_seg[d] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0; pv = 1'b0;
        a_dp = '0; a_en = '0; p_dp = '0; p_en = '0;
        for (int d = 0; d < 4; d++) begin
          a_seg[d] = '0;
          p_seg[d] = '0;
        end
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
      end else begin
        int p, slot, cyc;
        p = k % FR;
        slot = p / RD;
        cyc = p % RD;
        k++;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        if (cyc >= BL && a_en[slot]) begin
          exp_an[slot] = 1'b0;
          exp_seg = ~a_seg[slot];
          exp_dp = ~a_dp[slot];
        end
        exp_fd = (p == FR - 1);
        if (p == FR - 1) begin
          if (load) begin
            for (int d = 0; d < 4; d++) a_seg[d] = seg_in[7*d +: 7];
            a_dp = dp_in; a_en = digit_en;
          end else if (pv) begin
            for (int d = 0; d < 4; d++) a_seg[d] = p_seg[d];
            a_dp = p_dp; a_en = p_en;
          end
          pv = 1'b0;
        end else if (load) begin
          for (int d = 0; d < 4; d++) p_seg[d] = seg_in[7*d +: 7];
          p_dp = dp_in; p_en = digit_en;
          pv = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("an_n", {28'd0, an_n}, {28'd0, exp_an});
      check("seg_n", {25'd0, seg_n}, {25'd0, exp_seg});
      check("dp_n", {31'd0, dp_n}, {31'd0, exp_dp});
      check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      if ((an_n == 4'b1110) || (an_n == 4'b1101) || (an_n == 4'b1011) ||
          (an_n == 4'b0111) || (an_n == 4'b1111)) begin
        vectors++;
      end else begin
        vectors++;
        misc++;
        $display("FAIL anode_onehot at edge %0d: got %b expected at most one low", k, an_n);
      end
    end
  end

  task automatic wait_edge(input int n);
    while (k < n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive a load so that it is sampled at edge n.
  task automatic do_load(input int n, input logic [27:0] s, input logic [3:0] dp, input logic [3:0] en);
    wait_edge(n - 1);
    seg_in = s; dp_in = dp; digit_en = en; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  localparam logic [27:0] SEG_P = {7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [27:0] SEG_A = {7'h01, 7'h02, 7'h03, 7'h71};
  localparam logic [27:0] SEG_B = {7'h11, 7'h22, 7'h33, 7'h7F};
  localparam logic [27:0] SEG_C = {7'h44, 7'h55, 7'h66, 7'h07};
  localparam logic [27:0] SEG_D = {7'h0A, 7'h0B, 7'h0C, 7'h1C};

  initial begin
    // idle after reset: dark display, frame_done every 32 cycles
    do_reset();
    wait_edge(20); check("idle_an", {28'd0, an_n}, 32'h0000000F);
    check("idle_seg", {25'd0, seg_n}, 32'h0000007F);
    wait_edge(31); check("fd_31", {31'd0, frame_done}, 32'd0);
    wait_edge(32); check("fd_32", {31'd0, frame_done}, 32'd1);
    wait_edge(33); check("fd_33", {31'd0, frame_done}, 32'd0);
    wait_edge(64); check("fd_64", {31'd0, frame_done}, 32'd1);

    // load at edge 1, visible from frame 2
    do_reset();
    do_load(1, SEG_P, 4'h0, 4'hF);
    wait_edge(34); check("blank_34", {28'd0, an_n}, 32'h0000000F);
    wait_edge(35); check("d0_an_35", {28'd0, an_n}, 32'h0000000E);
    check("d0_seg_35", {25'd0, seg_n}, 32'h00000040);
    wait_edge(40); check("d0_seg_40", {25'd0, seg_n}, 32'h00000040);
    wait_edge(41); check("blank_41", {28'd0, an_n}, 32'h0000000F);
    wait_edge(43); check("d1_an_43", {28'd0, an_n}, 32'h0000000D);
    check("d1_seg_43", {25'd0, seg_n}, 32'h00000079);
    wait_edge(48); check("d1_seg_48", {25'd0, seg_n}, 32'h00000079);

    // digit 2 disabled
    do_load(66, SEG_P, 4'h0, 4'b1011);
    wait_edge(109); check("en_d1_an", {28'd0, an_n}, 32'h0000000D);
    wait_edge(117); check("en_d2_off", {28'd0, an_n}, 32'h0000000F);
    wait_edge(125); check("en_d3_an", {28'd0, an_n}, 32'h00000007);
    check("en_d3_seg", {25'd0, seg_n}, 32'h00000030);

    // two loads in a frame: last wins
    do_load(130, SEG_A, 4'h0, 4'hF);
    do_load(140, SEG_B, 4'h1, 4'hF);
    wait_edge(163); check("last_wins_seg", {25'd0, seg_n}, 32'h00000000);
    check("last_wins_dp", {31'd0, dp_n}, 32'd0);

    // pending D overridden by a load on the boundary edge
    do_load(170, SEG_D, 4'h0, 4'hF);
    do_load(192, SEG_C, 4'h0, 4'hF);
    wait_edge(195); check("bypass_seg", {25'd0, seg_n}, 32'h00000078);
    wait_edge(228); check("pre_rst_an", {28'd0, an_n}, 32'h0000000E);
    check("pre_rst_seg", {25'd0, seg_n}, 32'h00000078);

    // asynchronous reset between edges
    #1 rst_n = 1'b0;
    #1;
    check("arst_an", {28'd0, an_n}, 32'h0000000F);
    check("arst_seg", {25'd0, seg_n}, 32'h0000007F);
    check("arst_dp", {31'd0, dp_n}, 32'd1);
    check("arst_fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edge(3); check("post_rst_an", {28'd0, an_n}, 32'h0000000F);
    wait_edge(40); check("post_rst_seg", {25'd0, seg_n}, 32'h0000007F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
